kernel_cc_start_token_rx: RTL and testbench
===========================================

Name: kernel_cc_start_token_rx

Overview:
- Read-side controller for a kernel_cc start FIFO (start_for_* channels).
- Pops one start token per invocation and drives the ap_start/ap_ready/ap_done/ap_continue handshake of the downstream dataflow process (e.g. write_back).
- Tracks outstanding runs, returns completion to the upstream controller, and counts completed runs.
- Sits between the start FIFO read port and the consumer process's block-level control.

Parameters:
- MAX_OUTSTANDING, 2, maximum runs started (ap_ready seen) but not yet completion-acknowledged; legal range 1..15.
- CNT_WIDTH, 16, width of the completed-run counter.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- start_fifo_empty_n  in  1  start FIFO holds at least one token.
- start_fifo_read  out  1  pop request; a token is consumed when start_fifo_read=1 and start_fifo_empty_n=1 in the same cycle.
- proc_ap_start  out  1  start to the downstream process.
- proc_ap_ready  in  1  downstream process has accepted the start.
- proc_ap_done  in  1  single-cycle completion pulse from the downstream process.
- proc_ap_continue  out  1  completion acknowledge to the downstream process.
- done_valid  out  1  a completion is pending for the upstream controller.
- done_ack  in  1  upstream accepts the pending completion.
- outstanding  out  4  runs started and not yet acknowledged.
- run_count  out  CNT_WIDTH  completed (acknowledged) runs; wraps modulo 2^CNT_WIDTH.
- busy  out  1  high when state=START or outstanding!=0 or done_valid=1.

Behaviour:
- Reset (ap_rst_n=0 at an edge):
  - state=IDLE; proc_ap_start=0, done_valid=0, outstanding=0, run_count=0.
  - Combinational outputs evaluate to 0.
  - Reset mid-run abandons any in-flight token; the start FIFO is reset together with this block.
- State machine, two states:
  - IDLE: start_fifo_read = start_fifo_empty_n & (outstanding < MAX_OUTSTANDING). This is combinational from registered state and the input. If it is 1, go to START and set proc_ap_start=1 at that edge. Otherwise stay in IDLE with start_fifo_read=0.
  - START: proc_ap_start stays at 1 and start_fifo_read=0. When proc_ap_ready=1, clear proc_ap_start at that edge, increment outstanding and return to IDLE.
- Latency:
  - Token pop to proc_ap_start high is 1 cycle.
  - ap_ready to the next possible pop is 1 cycle (IDLE cycle).
  - Back-to-back runs therefore start at most every 2 cycles.
- Completion path:
  - proc_ap_done=1 sets done_valid at the next edge.
  - proc_ap_continue = done_valid & done_ack, combinational.
  - At the edge where done_valid & done_ack: clear done_valid, decrement outstanding, increment run_count.
  - If proc_ap_done=1 in the same cycle as done_valid & done_ack, done_valid stays 1 for the new completion.
  - proc_ap_done while done_valid=1 and done_ack=0 is a protocol violation. The downstream process must not do this because it holds ap_done until ap_continue. The bench asserts on it.
- Simultaneous increment (ap_ready accept) and decrement (ack) in one cycle: outstanding is unchanged.
- Full: outstanding=MAX_OUTSTANDING blocks pops; tokens remain in the FIFO.
- Empty: start_fifo_empty_n=0 produces no read and no start. The block never issues a read while empty_n=0.
- outstanding never underflows. An ack with outstanding=0 cannot occur because done_valid implies a started run.
- run_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.

Test Plan:
- Reset, then empty_n=0 for 10 cycles -> start_fifo_read=0, proc_ap_start=0, busy=0, run_count=0 throughout.
- Single token:
  - Stimulus: empty_n=1 for 1 cycle, ap_ready 3 cycles later, ap_done 5 cycles later, done_ack held 1.
  - Required: 1 read; ap_start high for exactly 4 cycles; proc_ap_continue 1 cycle; outstanding 0→1→0; run_count=1.
- MAX_OUTSTANDING=2 with 4 tokens queued, ap_ready immediate, no ap_done:
  - Required: exactly 2 reads, 2 starts, spaced 2 cycles apart; outstanding=2; start_fifo_read stuck at 0.
  - Then one done+ack -> outstanding=1; the third read occurs the cycle after.
- Same-cycle ap_ready and ack with outstanding=1 -> outstanding stays 1; run_count increments by 1.
- done_ack withheld 6 cycles after ap_done -> done_valid held high; proc_ap_continue=0 until ack; no outstanding change until ack.
- ap_rst_n=0 asserted while state=START with outstanding=1 -> next cycle ap_start=0, outstanding=0, done_valid=0. A token present after release is popped normally.
- CNT_WIDTH=4, 17 completed runs -> run_count=1 (wrapped).

Source files
------------

// File: rtl/kernel_cc_start_token_rx.sv
// kernel_cc_start_token_rx: pops start tokens and drives a dataflow process's ap_start/ap_continue handshake
module kernel_cc_start_token_rx #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic                 start_fifo_empty_n,
  output logic                 start_fifo_read,
  output logic                 proc_ap_start,
  input  logic                 proc_ap_ready,
  input  logic                 proc_ap_done,
  output logic                 proc_ap_continue,
  output logic                 done_valid,
  input  logic                 done_ack,
  output logic [3:0]           outstanding,
  output logic [CNT_WIDTH-1:0] run_count,
  output logic                 busy
);
  typedef enum logic {IDLE, START} state_e;
  state_e               state_q, state_d;
  logic                 done_valid_q, done_valid_d;
  logic [3:0]           outstanding_q, outstanding_d;
  logic [CNT_WIDTH-1:0] run_count_q, run_count_d;
  logic                 accepted, acked;
  // combinational outputs are forced low while reset is held
  always_comb begin
    start_fifo_read = ap_rst_n && state_q == IDLE && start_fifo_empty_n && outstanding_q < 4'(MAX_OUTSTANDING);
    accepted = state_q == START && proc_ap_ready;
    acked = done_valid_q && done_ack;
    proc_ap_continue = ap_rst_n && acked;
    busy = ap_rst_n && (state_q == START || outstanding_q != 4'd0 || done_valid_q);
    state_d = start_fifo_read ? START : accepted ? IDLE : state_q;
    outstanding_d = outstanding_q + 4'(accepted) - 4'(acked);
    done_valid_d = proc_ap_done || (done_valid_q && !done_ack);
    run_count_d = run_count_q + CNT_WIDTH'(acked);
  end
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      done_valid_q <= 1'b0;
      outstanding_q <= 4'd0;
      run_count_q <= '0;
    end else begin
      state_q <= state_d;
      done_valid_q <= done_valid_d;
      outstanding_q <= outstanding_d;
      run_count_q <= run_count_d;
    end
  end
  assign proc_ap_start = state_q == START;
  assign done_valid = done_valid_q;
  assign outstanding = outstanding_q;
  assign run_count = run_count_q;
endmodule

// File: tb/tb_kernel_cc_start_token_rx.sv
// tb_kernel_cc_start_token_rx: directed and random checks against a run-level model of the start-token handshake
module tb_kernel_cc_start_token_rx;
  localparam int MAXO = 2;
  localparam int CW = 4;
  logic clk = 1'b0, rst_n = 1'b0, ready = 1'b0, done = 1'b0, ack = 1'b0;
  int fifo_cnt = 0;
  logic empty_n, rd, st, cont, dv, busy;
  logic [3:0] outst;
  logic [CW-1:0] rc;
  int n_cmp = 0, n_bad = 0, n_read = 0, n_start = 0, n_cont = 0;
  bit m_pend = 0, m_dv = 0;
  int m_out = 0, m_runs = 0, m_running = 0;

  assign empty_n = fifo_cnt > 0;
  always #5 clk = ~clk;

  kernel_cc_start_token_rx #(.MAX_OUTSTANDING(MAXO), .CNT_WIDTH(CW)) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .start_fifo_empty_n(empty_n), .start_fifo_read(rd),
    .proc_ap_start(st), .proc_ap_ready(ready), .proc_ap_done(done), .proc_ap_continue(cont),
    .done_valid(dv), .done_ack(ack), .outstanding(outst), .run_count(rc), .busy(busy)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // m_pend: a popped token whose run the process has not yet accepted
  task automatic cyc();
    bit e_read, e_cont, e_busy, acc, ackd;
    @(negedge clk);
    e_read = rst_n && !m_pend && fifo_cnt > 0 && m_out < MAXO;
    e_cont = rst_n && m_dv && ack;
    e_busy = rst_n && (m_pend || m_out != 0 || m_dv);
    chk("read", rd, e_read);
    chk("start", st, m_pend);
    chk("continue", cont, e_cont);
    chk("done_valid", dv, m_dv);
    chk("outstanding", outst, m_out);
    chk("run_count", rc, m_runs % (1 << CW));
    chk("busy", busy, e_busy);
    n_cmp++;
    assert (!(rst_n && done && m_dv && !ack)) else begin
      n_bad++;
      $error("FAIL protocol: ap_done with unacked completion, observed 1 expected 0");
    end
    n_read += int'(rd && empty_n);
    n_start += int'(st);
    n_cont += int'(cont);
    acc = m_pend && ready;
    ackd = m_dv && ack;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_pend = 0; m_dv = 0; m_out = 0; m_runs = 0; m_running = 0; fifo_cnt = 0;
    end else begin
      if (e_read) begin
        fifo_cnt--;
        m_pend = 1;
      end else if (acc) m_pend = 0;
      m_out += int'(acc) - int'(ackd);
      m_running += int'(acc) - int'(done);
      m_dv = done || (m_dv && !ack);
      m_runs += int'(ackd);
    end
  endtask

  task automatic run(int n, bit r, bit d, bit a);
    ready = r; done = d; ack = a;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rst_n = 0;
    run(2, 0, 0, 0);
    rst_n = 1;
  endtask

  initial begin
    do_reset();
    run(10, 0, 0, 0);
    chk("idle_run_count", rc, 0);
    chk("idle_busy", busy, 0);
    chk("idle_read", rd, 0);

    n_read = 0; n_start = 0; n_cont = 0;
    fifo_cnt = 1;
    ack = 1;
    for (int i = 0; i < 14; i++) begin
      ready = (i == 4);
      done = (i == 9);
      cyc();
    end
    chk("single_reads", n_read, 1);
    chk("single_start_cycles", n_start, 4);
    chk("single_continue", n_cont, 1);
    chk("single_runs", rc, 1);
    chk("single_outstanding", outst, 0);

    n_read = 0; n_start = 0;
    fifo_cnt = 4;
    run(8, 1, 0, 0);
    chk("full_reads", n_read, 2);
    chk("full_starts", n_start, 2);
    chk("full_outstanding", outst, 2);
    chk("full_blocked_read", rd, 0);
    run(1, 1, 1, 1);
    run(1, 1, 0, 1);
    chk("full_after_ack", outst, 1);
    chk("full_third_read", rd, 1);
    run(3, 1, 0, 0);
    chk("full_reads_total", n_read, 3);

    do_reset();
    fifo_cnt = 1;
    run(2, 1, 0, 0);
    fifo_cnt = 1;
    run(1, 0, 1, 0);
    run(1, 1, 0, 1);
    chk("simul_outstanding", outst, 1);
    chk("simul_runs", rc, 1);

    run(1, 0, 1, 0);
    run(6, 0, 0, 0);
    chk("withheld_dv", dv, 1);
    chk("withheld_cont", cont, 0);
    chk("withheld_outstanding", outst, 1);
    run(1, 0, 0, 1);
    chk("released_outstanding", outst, 0);
    chk("released_runs", rc, 2);

    fifo_cnt = 1;
    run(2, 1, 0, 0);
    fifo_cnt = 1;
    run(2, 0, 0, 0);
    chk("pre_reset_start", st, 1);
    rst_n = 0;
    run(1, 0, 0, 0);
    rst_n = 1;
    chk("reset_start", st, 0);
    chk("reset_outstanding", outst, 0);
    chk("reset_dv", dv, 0);
    n_read = 0;
    fifo_cnt = 1;
    run(3, 1, 0, 0);
    chk("post_reset_reads", n_read, 1);
    chk("post_reset_outstanding", outst, 1);

    do_reset();
    for (int k = 0; k < 17; k++) begin
      fifo_cnt = 1;
      run(2, 1, 0, 0);
      run(1, 0, 1, 0);
      run(1, 0, 0, 1);
    end
    chk("wrap_run_count", rc, 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) fifo_cnt++;
      ready = 1'($urandom_range(0, 1));
      ack = $urandom_range(0, 2) != 0;
      done = m_running > 0 && !(m_dv && !ack) && $urandom_range(0, 3) == 0;
      rst_n = $urandom_range(0, 199) != 0;
      cyc();
    end
    rst_n = 1;
    run(2, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
